// File: rtl/muldiv_unit_ex.sv
// Iterative RV32M multiply/divide unit for the EX stage: one shift-add or
// restoring-subtract step per cycle, stalling the pipeline until the result is ready.
module muldiv_unit_ex #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [4:0]      ALUOp,
  input  logic            flush,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  // M-extension ALUOp codes: 5'b10fff, where fff selects the operation
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(XLEN);

  logic [1:0]        state;
  logic [4:0]        op;
  logic [XLEN-1:0]   mcand;     // multiplicand magnitude, or divisor magnitude
  logic [2*XLEN-1:0] prod;      // product; low half doubles as dividend/quotient
  logic [XLEN:0]     rem;
  logic [CW-1:0]     cnt;
  logic              neg_res, neg_rem;

  logic            is_m, is_div, sgn_a, sgn_b, sa, sb;
  logic            div0, ovf, special, start;
  logic [XLEN-1:0] a_abs, b_abs, spec_res;
  logic [XLEN:0]   sum, sh, diff;
  logic [2*XLEN-1:0] p_fix;
  logic [XLEN-1:0] q_fix, r_fix;
  logic            unused_rem_msb;

  always_comb begin
    is_m   = (ALUOp >= OP_MUL) && (ALUOp <= OP_REMU);
    is_div = is_m && ALUOp[2];
    sgn_a  = (ALUOp == OP_MUL) || (ALUOp == OP_MULH) || (ALUOp == OP_MULHSU) ||
             (ALUOp == OP_DIV) || (ALUOp == OP_REM);
    sgn_b  = (ALUOp == OP_MUL) || (ALUOp == OP_MULH) ||
             (ALUOp == OP_DIV) || (ALUOp == OP_REM);
    sa     = sgn_a && op_a[XLEN-1];
    sb     = sgn_b && op_b[XLEN-1];
    a_abs  = sa ? -op_a : op_a;
    b_abs  = sb ? -op_b : op_b;
    div0   = is_div && (op_b == '0);
    ovf    = ((ALUOp == OP_DIV) || (ALUOp == OP_REM)) &&
             (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special = div0 || ovf;
    // Overflow DIV returns the dividend itself (most negative value)
    if (ALUOp[1]) spec_res = div0 ? op_a : '0;
    else          spec_res = div0 ? '1 : op_a;
    start  = valid_in && is_m && !flush && (state == S_IDLE);
  end

  always_comb begin
    sum   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, mcand};
    sh    = {rem[XLEN-1:0], prod[XLEN-1]};
    diff  = sh - {1'b0, mcand};
    p_fix = neg_res ? -prod : prod;
    q_fix = neg_res ? -prod[XLEN-1:0] : prod[XLEN-1:0];
    r_fix = neg_rem ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    unused_rem_msb = rem[XLEN];
  end

  assign busy = start || (state == S_CALC) || (state == S_SIGN);
  assign done = (state == S_DONE) && !flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      op      <= '0;
      mcand   <= '0;
      prod    <= '0;
      rem     <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op      <= ALUOp;
          mcand   <= is_div ? b_abs : a_abs;
          prod    <= {{XLEN{1'b0}}, is_div ? a_abs : b_abs};
          rem     <= '0;
          cnt     <= CW'(XLEN-1);
          neg_res <= sa ^ sb;
          neg_rem <= sa;
          if (special) begin
            result <= spec_res;
            state  <= S_DONE;
          end else begin
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (op[2]) begin
            // Restoring step: diff MSB set means the trial subtract underflowed
            rem  <= diff[XLEN] ? sh : diff;
            prod <= {prod[2*XLEN-1:XLEN], prod[XLEN-2:0], ~diff[XLEN]};
          end else if (prod[0]) begin
            prod <= {sum, prod[XLEN-1:1]};
          end else begin
            prod <= {1'b0, prod[2*XLEN-1:1]};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= S_SIGN;
        end
        S_SIGN: begin
          case (op)
            OP_MUL:                     result <= p_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                   result <= p_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            result <= q_fix;
            default:                    result <= r_fix;
          endcase
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/muldiv_unit_ex.md
Name: muldiv_unit_ex

Overview:
- Iterative M-extension execution unit in the EX stage.
- Consumes the 5-bit ALUOp produced by the EX-stage ALU control decoder and the two EX operands.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles.
- Stalls the pipeline through the hazard unit until the result is ready, then presents it for one cycle for writeback selection.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- valid_in  input  1  EX instruction valid (not a bubble).
- ALUOp  input  5  op code from the shared constants header (`MUL..`REMU); any other code is ignored.
- flush  input  1  kills the in-flight operation (branch/exception).
- op_a  input  XLEN  rs1 value (dividend / multiplicand).
- op_b  input  XLEN  rs2 value (divisor / multiplier).
- busy  output  1  stall request to the hazard unit.
- done  output  1  one-cycle result-valid strobe.
- result  output  XLEN  final result.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, busy=0, done=0, result=0, all internal accumulators and counter = 0.
- start = valid_in & (ALUOp is one of the 8 M codes) & ~flush & (state==IDLE).
- busy (combinational) = start | (state==CALC) | (state==SIGN). It is low in DONE, which releases the stall.
- State machine:
  - IDLE → CALC on start. Latch the op. Latch operand magnitudes: signed ops take abs(); MULHSU takes abs of op_a only; unsigned ops take raw values. Record neg_result and neg_rem. Set counter = XLEN-1.
  - IDLE → DONE on start when the op is a special case. Special cases: divide-by-zero, or signed overflow (op_a = 0x80000000, op_b = 0xFFFFFFFF, DIV/REM).
  - CALC: one shift-add step (multiply) or one restoring subtract step (divide) per cycle. Exit to SIGN when counter==0, giving exactly XLEN CALC cycles.
  - SIGN: apply the two's-complement correction and select the output:
    - MUL: low XLEN bits of the 2·XLEN product.
    - MULH/MULHSU/MULHU: high XLEN bits.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
    - Register into result; → DONE.
  - DONE: done=1 for exactly one cycle; → IDLE unconditionally. A start in DONE is not possible (the pipeline advances that cycle); any such start is ignored.
- Latency: the start cycle is cycle 0; done=1 in cycle XLEN+2 (34) for the normal path and in cycle 1 for special cases.
- result holds its value after DONE until the next SIGN or special-case update.
- Special-case results (RISC-V spec):
  - DIV/DIVU by 0: quotient = all ones.
  - REM/REMU by 0: remainder = op_a.
  - Signed overflow: DIV result = 0x80000000, REM result = 0.
- Sign rules:
  - Quotient is negated iff the operand signs differ (signed ops only).
  - Remainder takes the dividend's sign.
  - MULH product is negated iff the signs differ; MULHSU product is negated iff op_a < 0.
- Arithmetic width: the product accumulator is 2·XLEN; the partial remainder is XLEN+1 bits.
- flush in any state: next state IDLE, no done pulse, result unchanged. flush has priority over start in the same cycle.
- Operand changes on op_a/op_b while in CALC are ignored, because the latched copies are used.
- Non-M ALUOp or valid_in=0 in IDLE: stays IDLE, busy=0.

Test Plan:
- Reset mid-CALC (reset low at cycle 10) → busy=0, done=0 and result=0 immediately; the next MUL 3×4 completes normally with result=12.
- MUL op_a=0xFFFFFFFF (−1), op_b=5 → busy high cycles 0–33, done at cycle 34, result=0xFFFFFFFB. MULH on the same operands → 0xFFFFFFFF. MULHU on the same operands → 0x00000004.
- MULHSU op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → result=0xFFFFFFFF. MUL 0x10000×0x10000 → 0; MULHU on the same operands → 1.
- DIV −7/2 → 0xFFFFFFFD (−3); REM −7/2 → 0xFFFFFFFF (−1); DIVU 7/2 → 3; REMU 7/2 → 1, each with done at cycle 34.
- DIV 5/0 → done at cycle 1, result 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM on the same operands → 0.
- MUL started, flush at cycle 10 → busy drops next cycle, no done, result keeps its prior value. Flush coincident with start → stays IDLE, busy=0. ALUOp=`ADD with valid_in=1 → busy never asserts.
